// File: rtl/run_sequencer_if.sv
// run_sequencer_if: groups the run sequencer's host, preload, memory and core signals.
//   master : host/bench side; drives go, abort, the load stream and core_halt.
//   slave  : sequencer side; drives ld_ready, memory write port, core_start and status.
// Signals:
//   go, abort                   run request / return-to-idle
//   ld_valid/ready/addr/data/last  preload word stream (valid/ready)
//   mem_we/addr/wdata, mem_reset   data-memory write port and clear
//   core_start, core_halt          core init line and its done flag
//   busy, done, timeout, run_cycles, words_loaded  run status
interface run_sequencer_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          go;
    logic          abort;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_reset;
    logic          core_start;
    logic          core_halt;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [15:0]   run_cycles;
    logic [AW:0]   words_loaded;

    modport master (
        output go, abort, ld_valid, ld_addr, ld_data, ld_last, core_halt,
        input  ld_ready, mem_we, mem_addr, mem_wdata, mem_reset, core_start,
               busy, done, timeout, run_cycles, words_loaded
    );

    modport slave (
        input  go, abort, ld_valid, ld_addr, ld_data, ld_last, core_halt,
        output ld_ready, mem_we, mem_addr, mem_wdata, mem_reset, core_start,
               busy, done, timeout, run_cycles, words_loaded
    );
endinterface

// File: rtl/run_sequencer.sv
// run_sequencer: owns the core's init line and the data-memory reset. Clears and
// preloads data memory from a valid/ready word stream, releases the core, then
// watches core_halt with a watchdog. Back-to-back runs need no global reset.
// Ports:
//   CLK    clock, posedge
//   reset  asynchronous active-low reset
//   bus    run_sequencer_if.slave (load stream in, memory write port, core
//          start/halt, status: busy, done, timeout, run_cycles, words_loaded)
// busy and ld_ready decode directly from state; every other output is registered.
module run_sequencer #(
    parameter int unsigned START_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 16'hFFFF,
    parameter int unsigned AW           = 8,
    parameter int unsigned DW           = 8
) (
    input logic            CLK,
    input logic            reset,
    run_sequencer_if.slave bus
);

    localparam int unsigned SCW = $clog2(START_CYCLES) + 1;
    localparam int unsigned RCW = 16;
    localparam int unsigned WLW = AW + 1;

    localparam logic [SCW-1:0] START_LOAD = SCW'(START_CYCLES - 1);
    localparam logic [RCW-1:0] RUN_LIMIT  = RCW'(TIMEOUT - 1);
    localparam logic [WLW-1:0] WL_MAX     = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD,
        S_DRAIN,
        S_RUN,
        S_DONE,
        S_TOUT
    } state_t;

    state_t         state_q, state_d;
    logic [SCW-1:0] start_cnt_q, start_cnt_d;
    logic           mem_we_q, mem_we_d;
    logic [AW-1:0]  mem_addr_q, mem_addr_d;
    logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
    logic           mem_reset_q, mem_reset_d;
    logic           core_start_q, core_start_d;
    logic           done_q, done_d;
    logic           timeout_q, timeout_d;
    logic [RCW-1:0] run_cycles_q, run_cycles_d;
    logic [WLW-1:0] words_loaded_q, words_loaded_d;

    // State and registered outputs
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            start_cnt_q    <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_reset_q    <= 1'b0;
            core_start_q   <= 1'b1;
            done_q         <= 1'b0;
            timeout_q      <= 1'b0;
            run_cycles_q   <= '0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            start_cnt_q    <= start_cnt_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_reset_q    <= mem_reset_d;
            core_start_q   <= core_start_d;
            done_q         <= done_d;
            timeout_q      <= timeout_d;
            run_cycles_q   <= run_cycles_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_d        = state_q;
        start_cnt_d    = start_cnt_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        done_d         = done_q;
        timeout_d      = timeout_q;
        run_cycles_d   = run_cycles_q;
        words_loaded_d = words_loaded_q;

        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (start_cnt_q == '0) begin
                    state_d = S_LOAD;
                end else begin
                    start_cnt_d = start_cnt_q - SCW'(1);
                end
            end

            S_LOAD: begin
                // ld_ready is high throughout LOAD, so ld_valid alone marks a transfer
                if (bus.ld_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = bus.ld_addr;
                    mem_wdata_d = bus.ld_data;
                    if (words_loaded_q != WL_MAX) begin
                        words_loaded_d = words_loaded_q + WLW'(1);
                    end
                    if (bus.ld_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                state_d = S_RUN;
            end

            S_RUN: begin
                // Halt beats the watchdog when both land on the same cycle
                if (bus.core_halt) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (run_cycles_q == RUN_LIMIT) begin
                    state_d   = S_TOUT;
                    timeout_d = 1'b1;
                end else begin
                    run_cycles_d = run_cycles_q + RCW'(1);
                end
            end

            S_DONE, S_TOUT: begin
                if (bus.go) begin
                    state_d = S_START;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything: drop any in-flight word, keep the status
        if (bus.abort) begin
            state_d        = S_IDLE;
            start_cnt_d    = start_cnt_q;
            mem_we_d       = 1'b0;
            mem_addr_d     = mem_addr_q;
            mem_wdata_d    = mem_wdata_q;
            done_d         = done_q;
            timeout_d      = timeout_q;
            run_cycles_d   = run_cycles_q;
            words_loaded_d = words_loaded_q;
        end

        // Every entry to START begins a fresh run
        if ((state_d == S_START) && (state_q != S_START)) begin
            start_cnt_d    = START_LOAD;
            done_d         = 1'b0;
            timeout_d      = 1'b0;
            run_cycles_d   = '0;
            words_loaded_d = '0;
        end

        // Level outputs follow the state being entered so they align with it
        mem_reset_d  = (state_d == S_START);
        core_start_d = !((state_d == S_RUN) || (state_d == S_DONE));
    end

    assign bus.busy         = (state_q == S_START) || (state_q == S_LOAD) ||
                              (state_q == S_DRAIN) || (state_q == S_RUN);
    assign bus.ld_ready     = (state_q == S_LOAD);
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_reset    = mem_reset_q;
    assign bus.core_start   = core_start_q;
    assign bus.done         = done_q;
    assign bus.timeout      = timeout_q;
    assign bus.run_cycles   = run_cycles_q;
    assign bus.words_loaded = words_loaded_q;

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: drives two sequencers (default watchdog and TIMEOUT=16) through
// preload, run, halt, timeout, abort and asynchronous reset. Expected memory
// writes are queued when a handshake is driven and matched against mem_we.
module tb_run_sequencer;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic CLK   = 1'b0;
    logic reset = 1'b1;

    always #5 CLK = ~CLK;

    run_sequencer_if #(.AW(AW), .DW(DW)) bus_a ();
    run_sequencer_if #(.AW(AW), .DW(DW)) bus_t ();

    run_sequencer #(.START_CYCLES(2), .TIMEOUT(16'hFFFF), .AW(AW), .DW(DW)) dut_a (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus_a)
    );

    run_sequencer #(.START_CYCLES(2), .TIMEOUT(16), .AW(AW), .DW(DW)) dut_t (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus_t)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  cyc      = 0;
    int  checks   = 0;
    int  failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard: every dut_a memory write must match the oldest queued handshake
    always @(negedge CLK) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("wr_missing", 32'(exp_q[0].cyc), 32'(cyc));
            void'(exp_q.pop_front());
        end
        if (bus_a.mem_we) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(bus_a.mem_we), 32'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr",  32'(bus_a.mem_addr),  32'(mon_e.addr));
                check("wr_data",  32'(bus_a.mem_wdata), 32'(mon_e.data));
                check("wr_cycle", 32'(cyc),             32'(mon_e.cyc));
            end
        end
    end

    // Go, then wait through START for ld_ready, measuring the mem_reset pulse
    task automatic start_run_a();
        int mr;
        int t;
        bus_a.go = 1'b1;
        step();
        bus_a.go = 1'b0;
        check("start_busy",      32'(bus_a.busy),         32'(1));
        check("start_cs",        32'(bus_a.core_start),   32'(1));
        check("start_done_clr",  32'(bus_a.done),         32'(0));
        check("start_tout_clr",  32'(bus_a.timeout),      32'(0));
        check("start_rc_clr",    32'(bus_a.run_cycles),   32'(0));
        check("start_wl_clr",    32'(bus_a.words_loaded), 32'(0));
        mr = 0;
        t  = 0;
        while (!bus_a.ld_ready && t < 20) begin
            if (bus_a.mem_reset) mr++;
            t++;
            step();
        end
        check("start_to_load",  32'(bus_a.ld_ready),  32'(1));
        check("mem_reset_len",  32'(mr),              32'(2));
        check("load_mreset_lo", 32'(bus_a.mem_reset), 32'(0));
    endtask

    // Present one word for one cycle; queue its write if it will be accepted
    task automatic send_word(input logic [7:0] a, input logic [7:0] d, input logic last);
        bus_a.ld_valid = 1'b1;
        bus_a.ld_addr  = a;
        bus_a.ld_data  = d;
        bus_a.ld_last  = last;
        if (bus_a.ld_ready && !bus_a.abort) begin
            exp_q.push_back('{addr: a, data: d, cyc: cyc + 1});
        end
        step();
        bus_a.ld_valid = 1'b0;
        bus_a.ld_last  = 1'b0;
    endtask

    task automatic gap();
        bus_a.ld_valid = 1'b0;
        step();
        check("gap_ready", 32'(bus_a.ld_ready), 32'(1));
    endtask

    // From DRAIN: run the core, raising halt on RUN cycle halt_at
    task automatic run_core_a(input int halt_at, input bit pulses);
        check("drain_busy",  32'(bus_a.busy),       32'(1));
        check("drain_ready", 32'(bus_a.ld_ready),   32'(0));
        check("drain_cs",    32'(bus_a.core_start), 32'(1));
        step();
        check("run_cs", 32'(bus_a.core_start), 32'(0));
        for (int k = 0; k <= halt_at; k++) begin
            bus_a.core_halt = (k == halt_at);
            if (pulses && (k % 2 == 0)) begin
                bus_a.ld_valid = 1'b1;
                bus_a.ld_addr  = 8'(224 + k);
                bus_a.ld_data  = 8'($urandom);
                check("run_ready", 32'(bus_a.ld_ready), 32'(0));
            end else begin
                bus_a.ld_valid = 1'b0;
            end
            if (k == halt_at) check("run_count", 32'(bus_a.run_cycles), 32'(halt_at));
            step();
        end
        bus_a.ld_valid = 1'b0;
        check("done_done", 32'(bus_a.done),       32'(1));
        check("done_tout", 32'(bus_a.timeout),    32'(0));
        check("done_rc",   32'(bus_a.run_cycles), 32'(halt_at));
        check("done_cs",   32'(bus_a.core_start), 32'(0));
        check("done_busy", 32'(bus_a.busy),       32'(0));
        step();
        check("done_hold",    32'(bus_a.done),       32'(1));
        check("done_rc_hold", 32'(bus_a.run_cycles), 32'(halt_at));
        check("done_cs_hold", 32'(bus_a.core_start), 32'(0));
        bus_a.core_halt = 1'b0;
    endtask

    // dut_t: go, one-word preload, then run until halt (halt_at<0: never)
    task automatic run_t(input int halt_at, input logic [7:0] a, input logic [7:0] d);
        int t;
        int n;
        bus_t.go = 1'b1;
        step();
        bus_t.go = 1'b0;
        check("t_start_tout_clr", 32'(bus_t.timeout), 32'(0));
        t = 0;
        while (!bus_t.ld_ready && t < 20) begin
            t++;
            step();
        end
        check("t_load", 32'(bus_t.ld_ready), 32'(1));
        bus_t.ld_valid = 1'b1;
        bus_t.ld_addr  = a;
        bus_t.ld_data  = d;
        bus_t.ld_last  = 1'b1;
        step();
        bus_t.ld_valid = 1'b0;
        bus_t.ld_last  = 1'b0;
        check("t_wr_we",   32'(bus_t.mem_we),    32'(1));
        check("t_wr_addr", 32'(bus_t.mem_addr),  32'(a));
        check("t_wr_data", 32'(bus_t.mem_wdata), 32'(d));
        step();
        n = 0;
        while (bus_t.busy && !bus_t.core_start && n < 100) begin
            bus_t.core_halt = (n == halt_at);
            n++;
            step();
        end
        bus_t.core_halt = 1'b0;
        check("t_run_len", 32'(n), 32'((halt_at < 0) ? 16 : halt_at + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus_a.go = 1'b0; bus_a.abort = 1'b0; bus_a.ld_valid = 1'b0; bus_a.ld_last = 1'b0;
        bus_a.ld_addr = '0; bus_a.ld_data = '0; bus_a.core_halt = 1'b0;
        bus_t.go = 1'b0; bus_t.abort = 1'b0; bus_t.ld_valid = 1'b0; bus_t.ld_last = 1'b0;
        bus_t.ld_addr = '0; bus_t.ld_data = '0; bus_t.core_halt = 1'b0;

        #1 reset = 1'b0;
        repeat (3) step();
        check("rst_cs",     32'(bus_a.core_start),   32'(1));
        check("rst_mreset", 32'(bus_a.mem_reset),    32'(0));
        check("rst_we",     32'(bus_a.mem_we),       32'(0));
        check("rst_addr",   32'(bus_a.mem_addr),     32'(0));
        check("rst_wdata",  32'(bus_a.mem_wdata),    32'(0));
        check("rst_ready",  32'(bus_a.ld_ready),     32'(0));
        check("rst_busy",   32'(bus_a.busy),         32'(0));
        check("rst_done",   32'(bus_a.done),         32'(0));
        check("rst_tout",   32'(bus_a.timeout),      32'(0));
        check("rst_rc",     32'(bus_a.run_cycles),   32'(0));
        check("rst_wl",     32'(bus_a.words_loaded), 32'(0));
        reset = 1'b1;
        step();
        check("idle_cs", 32'(bus_a.core_start), 32'(1));

        // Run A: four-word preload, halt after 37 RUN cycles
        start_run_a();
        send_word(8'h00, 8'h11, 1'b0);
        send_word(8'h01, 8'h22, 1'b0);
        send_word(8'h02, 8'h33, 1'b0);
        send_word(8'h03, 8'h44, 1'b1);
        check("a_words", 32'(bus_a.words_loaded), 32'(4));
        run_core_a(37, 1'b0);

        // Run B from DONE: toggling ld_valid, stray ld_valid pulses during RUN
        start_run_a();
        send_word(8'h10, 8'hA0, 1'b0);
        gap();
        send_word(8'h11, 8'hA1, 1'b0);
        gap();
        send_word(8'h12, 8'hA2, 1'b1);
        check("b_words", 32'(bus_a.words_loaded), 32'(3));
        run_core_a(6, 1'b1);

        // Run C: abort on a handshake, then a fresh run with a one-word preload
        start_run_a();
        send_word(8'h20, 8'h55, 1'b0);
        bus_a.abort = 1'b1;
        send_word(8'h21, 8'h56, 1'b0);
        bus_a.abort = 1'b0;
        check("abort_we",     32'(bus_a.mem_we),       32'(0));
        check("abort_busy",   32'(bus_a.busy),         32'(0));
        check("abort_cs",     32'(bus_a.core_start),   32'(1));
        check("abort_ready",  32'(bus_a.ld_ready),     32'(0));
        check("abort_mreset", 32'(bus_a.mem_reset),    32'(0));
        check("abort_wl",     32'(bus_a.words_loaded), 32'(1));
        step();
        check("abort_idle", 32'(bus_a.busy), 32'(0));
        start_run_a();
        send_word(8'h30, 8'h66, 1'b1);
        check("c_words", 32'(bus_a.words_loaded), 32'(1));
        check("c_drain_busy", 32'(bus_a.busy), 32'(1));
        step();
        repeat (4) begin
            check("c_run_cs", 32'(bus_a.core_start), 32'(0));
            step();
        end
        check("c_run_rc", 32'(bus_a.run_cycles), 32'(4));

        // Asynchronous reset between edges while running
        #2 reset = 1'b0;
        #1;
        check("arst_cs",   32'(bus_a.core_start), 32'(1));
        check("arst_we",   32'(bus_a.mem_we),     32'(0));
        check("arst_done", 32'(bus_a.done),       32'(0));
        check("arst_busy", 32'(bus_a.busy),       32'(0));
        check("arst_rc",   32'(bus_a.run_cycles), 32'(0));
        step();
        reset = 1'b1;
        step();

        // Run D then a re-run from DONE (halt on the first RUN cycle)
        start_run_a();
        send_word(8'h40, 8'h77, 1'b0);
        send_word(8'h41, 8'h88, 1'b1);
        run_core_a(7, 1'b0);
        start_run_a();
        send_word(8'h50, 8'h99, 1'b1);
        run_core_a(0, 1'b0);

        // Watchdog instance: time out, then halt on the boundary cycle
        run_t(-1, 8'h5A, 8'hA5);
        check("t_tout",  32'(bus_t.timeout),    32'(1));
        check("t_done",  32'(bus_t.done),       32'(0));
        check("t_rc",    32'(bus_t.run_cycles), 32'(15));
        check("t_cs",    32'(bus_t.core_start), 32'(1));
        check("t_busy",  32'(bus_t.busy),       32'(0));
        step();
        check("t_tout_hold", 32'(bus_t.timeout), 32'(1));
        run_t(15, 8'h6B, 8'hB6);
        check("t2_done", 32'(bus_t.done),       32'(1));
        check("t2_tout", 32'(bus_t.timeout),    32'(0));
        check("t2_rc",   32'(bus_t.run_cycles), 32'(15));
        check("t2_cs",   32'(bus_t.core_start), 32'(0));

        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
